// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
//   Shared definitions for the Gray-code counter:
//     GRAY_MAX_WIDTH : widest counter supported (16 bits).
//     step_act_e     : the action taken on a clock edge, in priority order.
//     bin2gray       : binary -> Gray (XOR with itself shifted right by one).
//     gray2bin       : Gray -> binary (prefix XOR from the MSB down).
//   Both helpers work on GRAY_MAX_WIDTH bits. Callers zero-extend narrower
//   values and keep the low WIDTH bits of the result. Zero upper bits do not
//   disturb the low bits in either direction.
// -----------------------------------------------------------------------------
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_COUNT = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_CLR   = 2'd3
  } step_act_e;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
    input logic [GRAY_MAX_WIDTH-1:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
    input logic [GRAY_MAX_WIDTH-1:0] gray
  );
    logic [GRAY_MAX_WIDTH-1:0] bin;
    bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_next_logic.sv
// -----------------------------------------------------------------------------
// gray_next_logic
//   Purely combinational next-state logic for gray_code_counter.
//   Ports:
//     b_q      in  WIDTH  current registered binary count
//     en       in  1      count enable
//     up_dn    in  1      1 = increment, 0 = decrement
//     clr      in  1      clear to zero (highest priority)
//     load     in  1      load load_val (beats en)
//     load_val in  WIDTH  binary value to load
//     b_d      out WIDTH  next binary value
//     g_d      out WIDTH  Gray code of b_d, so the Gray register never lags
//     wrap_d   out 1      this edge is a count step that wraps modulo 2^WIDTH
// -----------------------------------------------------------------------------
module gray_next_logic
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] b_q,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] b_d,
  output logic [WIDTH-1:0] g_d,
  output logic             wrap_d
);

  step_act_e                 act;
  logic [GRAY_MAX_WIDTH-1:0] g_wide;

  // Priority: clear > load > count > hold.
  always_comb begin
    act = ACT_HOLD;
    if (clr) begin
      act = ACT_CLR;
    end else if (load) begin
      act = ACT_LOAD;
    end else if (en) begin
      act = ACT_COUNT;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    b_d    = b_q;
    wrap_d = 1'b0;
    unique case (act)
      ACT_CLR:  b_d = '0;
      ACT_LOAD: b_d = load_val;
      ACT_COUNT: begin
        if (up_dn) begin
          b_d    = b_q + WIDTH'(1);
          wrap_d = &b_q;   // all-ones rolls over to zero
        end else begin
          b_d    = b_q - WIDTH'(1);
          wrap_d = ~|b_q;  // zero rolls under to all-ones
        end
      end
      default: ;
    endcase
  end

  // Gray is derived from the next binary value. The Gray register then
  // loads the code for the same value that the binary register loads.
  assign g_wide = bin2gray(GRAY_MAX_WIDTH'(b_d));
  assign g_d    = g_wide[WIDTH-1:0];

  // The upper bits of the widened result are always zero and are not needed.
  if (WIDTH < GRAY_MAX_WIDTH) begin : g_pad
    logic [GRAY_MAX_WIDTH-WIDTH-1:0] unused_hi;
    assign unused_hi = g_wide[GRAY_MAX_WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/gray_code_counter.sv
// -----------------------------------------------------------------------------
// gray_code_counter
//   Binary up/down counter with a registered Gray-coded copy of the count.
//   Ports:
//     CLK      in  1      rising-edge clock
//     RST      in  1      asynchronous active-high reset
//     EN       in  1      count enable (one step per cycle)
//     UP_DN    in  1      1 = increment, 0 = decrement
//     CLR      in  1      synchronous clear (highest priority)
//     LOAD     in  1      synchronous load of LOAD_VAL
//     LOAD_VAL in  WIDTH  binary value to load
//     B_OUT    out WIDTH  registered binary count
//     G_OUT    out WIDTH  registered Gray code of B_OUT (same cycle, no skew)
//     TC       out 1      terminal count: B_OUT all-ones when counting up,
//                         zero when counting down (combinational)
//     WRAP     out 1      registered one-cycle pulse after a wrapping step
// -----------------------------------------------------------------------------
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP_DN,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] B_OUT,
  output logic [WIDTH-1:0] G_OUT,
  output logic             TC,
  output logic             WRAP
);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             wrap_q, wrap_d;

  gray_next_logic #(
    .WIDTH(WIDTH)
  ) u_next (
    .b_q     (b_q),
    .en      (EN),
    .up_dn   (UP_DN),
    .clr     (CLR),
    .load    (LOAD),
    .load_val(LOAD_VAL),
    .b_d     (b_d),
    .g_d     (g_d),
    .wrap_d  (wrap_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      b_q    <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples values from before the edge, whatever the statement order.
      b_q    <= b_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end

  // TC follows the live direction input, so a direction change is visible at once.
  assign TC    = UP_DN ? (&b_q) : (~|b_q);
  assign B_OUT = b_q;
  assign G_OUT = g_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_code_counter
//   Self-checking bench for gray_code_counter (WIDTH = 4). An integer model
//   of the count applies the edge rules with modulo arithmetic. Each test
//   task compares the DUT outputs with that model and with literal values.
// -----------------------------------------------------------------------------
module tb_gray_code_counter;
  import gray_pkg::*;

  localparam int W    = 4;
  localparam int MODV = 1 << W;

  logic         CLK;
  logic         RST;
  logic         EN;
  logic         UP_DN;
  logic         CLR;
  logic         LOAD;
  logic [W-1:0] LOAD_VAL;
  logic [W-1:0] B_OUT;
  logic [W-1:0] G_OUT;
  logic         TC;
  logic         WRAP;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_b = 0;
  bit m_wrap = 1'b0;

  gray_code_counter #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .UP_DN   (UP_DN),
    .CLR     (CLR),
    .LOAD    (LOAD),
    .LOAD_VAL(LOAD_VAL),
    .B_OUT   (B_OUT),
    .G_OUT   (G_OUT),
    .TC      (TC),
    .WRAP    (WRAP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Apply one clock edge of the behavioural rules to the model.
  task automatic model_edge();
    if (CLR) begin
      m_b = 0;
      m_wrap = 1'b0;
    end else if (LOAD) begin
      m_b = int'(LOAD_VAL);
      m_wrap = 1'b0;
    end else if (EN) begin
      if (UP_DN) begin
        m_wrap = (m_b == MODV - 1);
        m_b = (m_b + 1) % MODV;
      end else begin
        m_wrap = (m_b == 0);
        m_b = (m_b + MODV - 1) % MODV;
      end
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  function automatic logic [2*W+1:0] exp_vec();
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         tc;
    b  = W'(m_b);
    g  = b ^ (b >> 1);
    tc = UP_DN ? (m_b == MODV - 1) : (m_b == 0);
    return {b, g, m_wrap, tc};
  endfunction

  // Advance the model, then let one rising edge pass and settle.
  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; UP_DN = 1'b0; CLR = 1'b0; LOAD = 1'b0;
    LOAD_VAL = '0;
    m_b = 0; m_wrap = 1'b0;
    #3;  // before any rising edge
    n_checks++;
    if ({B_OUT, G_OUT, WRAP, TC} !== {W'(0), W'(0), 1'b0, 1'b1})
      $display("FAIL reset_async: got b=%0d g=%b w=%b tc=%b, expected 0/0000/0/1",
               B_OUT, G_OUT, WRAP, TC);
    else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    tick();
    n_checks++;
    if ({B_OUT, G_OUT, WRAP, TC} !== exp_vec())
      $display("FAIL reset_hold: got %b, expected %b", {B_OUT, G_OUT, WRAP, TC}, exp_vec());
    else n_pass++;
  endtask

  task automatic test_up_count();
    EN = 1'b1; UP_DN = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      n_checks++;
      if ({B_OUT, G_OUT, WRAP, TC} !== exp_vec() || int'(B_OUT) != (i + 1) % MODV)
        $display("FAIL up_count[%0d]: got %b, expected %b (b=%0d)",
                 i, {B_OUT, G_OUT, WRAP, TC}, exp_vec(), (i + 1) % MODV);
      else n_pass++;
    end
    EN = 1'b0;
  endtask

  task automatic test_down_wrap();
    int           tb_b[5];
    logic [W-1:0] tb_g[5];
    logic         tb_w[5];
    tb_b[0] = 2;  tb_b[1] = 1;  tb_b[2] = 0;  tb_b[3] = 15; tb_b[4] = 14;
    tb_g[0] = 4'b0011; tb_g[1] = 4'b0001; tb_g[2] = 4'b0000;
    tb_g[3] = 4'b1000; tb_g[4] = 4'b1001;
    tb_w[0] = 1'b0; tb_w[1] = 1'b0; tb_w[2] = 1'b0; tb_w[3] = 1'b1; tb_w[4] = 1'b0;
    LOAD = 1'b1; LOAD_VAL = 4'd2; EN = 1'b0; UP_DN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      LOAD = 1'b0; EN = 1'b1;
      n_checks++;
      if ({B_OUT, G_OUT, WRAP, TC} !== exp_vec() || int'(B_OUT) != tb_b[i] ||
          G_OUT !== tb_g[i] || WRAP !== tb_w[i])
        $display("FAIL down_wrap[%0d]: got b=%0d g=%b w=%b, expected b=%0d g=%b w=%b",
                 i, B_OUT, G_OUT, WRAP, tb_b[i], tb_g[i], tb_w[i]);
      else n_pass++;
    end
    EN = 1'b0;
  endtask

  task automatic test_priority();
    LOAD = 1'b1; LOAD_VAL = 4'd5; UP_DN = 1'b1;
    tick();
    CLR = 1'b1; LOAD = 1'b1; LOAD_VAL = 4'd9; EN = 1'b1;
    tick();
    n_checks++;
    if ({B_OUT, G_OUT, WRAP} !== {W'(0), W'(0), 1'b0} || {B_OUT, G_OUT, WRAP, TC} !== exp_vec())
      $display("FAIL prio_clear: got b=%0d g=%b w=%b, expected 0/0000/0", B_OUT, G_OUT, WRAP);
    else n_pass++;
    CLR = 1'b0;
    tick();
    n_checks++;
    if ({B_OUT, G_OUT, WRAP} !== {4'd9, 4'b1101, 1'b0} || {B_OUT, G_OUT, WRAP, TC} !== exp_vec())
      $display("FAIL prio_load: got b=%0d g=%b w=%b, expected 9/1101/0", B_OUT, G_OUT, WRAP);
    else n_pass++;
    LOAD = 1'b0; EN = 1'b0;
  endtask

  task automatic test_hold_dir();
    LOAD = 1'b1; LOAD_VAL = 4'd7; UP_DN = 1'b1;
    tick();
    LOAD = 1'b0; EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({B_OUT, G_OUT, WRAP} !== {4'd7, 4'b0100, 1'b0} || {B_OUT, G_OUT, WRAP, TC} !== exp_vec())
        $display("FAIL hold[%0d]: got b=%0d g=%b w=%b, expected 7/0100/0", i, B_OUT, G_OUT, WRAP);
      else n_pass++;
    end
    CLR = 1'b1;
    tick();
    CLR = 1'b0; UP_DN = 1'b1;
    #1;
    n_checks++;
    if (TC !== 1'b0 || B_OUT !== 4'd0)
      $display("FAIL dir_tc_up: got tc=%b b=%0d, expected tc=0 b=0", TC, B_OUT);
    else n_pass++;
    UP_DN = 1'b0;
    #1;
    n_checks++;
    if (TC !== 1'b1)
      $display("FAIL dir_tc_down: got tc=%b, expected 1", TC);
    else n_pass++;
  endtask

  task automatic test_load_all_ones();
    LOAD = 1'b1; LOAD_VAL = 4'hF; UP_DN = 1'b1; EN = 1'b1;
    tick();
    n_checks++;
    if ({B_OUT, WRAP, TC} !== {4'hF, 1'b0, 1'b1} || {B_OUT, G_OUT, WRAP, TC} !== exp_vec())
      $display("FAIL load_ones: got b=%0d w=%b tc=%b, expected 15/0/1", B_OUT, WRAP, TC);
    else n_pass++;
    LOAD = 1'b0; EN = 1'b0;
  endtask

  task automatic test_async_reset();
    LOAD = 1'b1; LOAD_VAL = 4'd10; UP_DN = 1'b1;
    tick();
    LOAD = 1'b0; EN = 1'b1;
    tick();
    tick();
    n_checks++;
    if (B_OUT !== 4'd12 || {B_OUT, G_OUT, WRAP, TC} !== exp_vec())
      $display("FAIL arst_pre: got b=%0d, expected 12", B_OUT);
    else n_pass++;
    #2 RST = 1'b1;
    m_b = 0; m_wrap = 1'b0;
    #1;
    n_checks++;
    if ({B_OUT, G_OUT, WRAP} !== {W'(0), W'(0), 1'b0})
      $display("FAIL arst_mid: got b=%0d g=%b w=%b, expected 0/0000/0", B_OUT, G_OUT, WRAP);
    else n_pass++;
    RST = 1'b0;
    tick();
    n_checks++;
    if (B_OUT !== 4'd1 || {B_OUT, G_OUT, WRAP, TC} !== exp_vec())
      $display("FAIL arst_resume: got b=%0d, expected 1", B_OUT);
    else n_pass++;
    // A wrap pulse in flight is cleared by reset.
    EN = 1'b0; LOAD = 1'b1; LOAD_VAL = 4'hF;
    tick();
    LOAD = 1'b0; EN = 1'b1;
    tick();
    n_checks++;
    if ({B_OUT, WRAP} !== {4'd0, 1'b1} || {B_OUT, G_OUT, WRAP, TC} !== exp_vec())
      $display("FAIL arst_wrap_pre: got b=%0d w=%b, expected 0/1", B_OUT, WRAP);
    else n_pass++;
    #2 RST = 1'b1;
    m_b = 0; m_wrap = 1'b0;
    #1;
    n_checks++;
    if (WRAP !== 1'b0 || B_OUT !== 4'd0)
      $display("FAIL arst_wrap_clr: got b=%0d w=%b, expected 0/0", B_OUT, WRAP);
    else n_pass++;
    RST = 1'b0;
    EN = 1'b0;
  endtask

  task automatic test_random_gray();
    logic [W-1:0]              prev_g;
    logic [GRAY_MAX_WIDTH-1:0] bw;
    logic                      en_step;
    int                        flips;
    CLR = 1'b0; LOAD = 1'b0;
    prev_g = G_OUT;
    for (int i = 0; i < 1000; i++) begin
      EN      = ($urandom_range(0, 3) != 0);
      UP_DN   = $urandom_range(0, 1) != 0;
      en_step = EN;
      tick();
      n_checks++;
      if ({B_OUT, G_OUT, WRAP, TC} !== exp_vec())
        $display("FAIL rnd_model[%0d]: got %b, expected %b", i, {B_OUT, G_OUT, WRAP, TC}, exp_vec());
      else n_pass++;
      bw = gray2bin(GRAY_MAX_WIDTH'(G_OUT));
      n_checks++;
      if (int'(bw) != m_b)
        $display("FAIL rnd_gray2bin[%0d]: got %0d, expected %0d", i, bw, m_b);
      else n_pass++;
      flips = $countones(G_OUT ^ prev_g);
      n_checks++;
      if (flips != (en_step ? 1 : 0))
        $display("FAIL rnd_onebit[%0d]: got %0d bit changes, expected %0d",
                 i, flips, en_step ? 1 : 0);
      else n_pass++;
      prev_g = G_OUT;
    end
    EN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_priority();
    test_hold_dir();
    test_load_all_ones();
    test_async_reset();
    test_random_gray();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gray_code_counter.md
Name: gray_code_counter

Overview:
- Synchronous binary up/down counter with a registered Gray-coded output.
- Sits directly upstream of the binary-to-Gray conversion path and supplies the binary sequence that stage consumes.
- Also carries the Gray value one register stage further, so downstream logic gets a glitch-free, single-bit-change code every clock.
- Used as the pointer/sequence source for Gray-code consumers, such as position encoders and FIFO pointers.

Parameters:
- WIDTH, 4, counter and output width in bits; legal range 2..16.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  count enable; counter steps one position per cycle while high.
- UP_DN  input  1  direction: 1 = increment, 0 = decrement.
- CLR  input  1  synchronous clear to zero.
- LOAD  input  1  synchronous load of LOAD_VAL.
- LOAD_VAL  input  WIDTH  binary value to load.
- B_OUT  output  WIDTH  registered binary count.
- G_OUT  output  WIDTH  registered Gray code of B_OUT; bit i = B_OUT[i] XOR B_OUT[i+1]; MSB = B_OUT MSB.
- TC  output  1  terminal count, combinational from B_OUT and UP_DN: all-ones when UP_DN=1, zero when UP_DN=0.
- WRAP  output  1  registered one-cycle pulse on a wrap step.

Behaviour:
- Reset:
  - RST high immediately forces B_OUT=0, G_OUT=0 and WRAP=0, with no clock needed.
  - TC then follows its rule (1 if UP_DN=0).
  - The first count step occurs on the first rising CLK edge after RST deasserts.
- Per-edge priority: CLR > LOAD > EN > hold.
  - CLR=1: B_OUT<=0, G_OUT<=0, WRAP<=0.
  - LOAD=1 (CLR=0): B_OUT<=LOAD_VAL, G_OUT<=bin2gray(LOAD_VAL), WRAP<=0.
  - EN=1 (CLR=0, LOAD=0): B_OUT<=B_OUT+1 mod 2^WIDTH when UP_DN=1, B_OUT-1 mod 2^WIDTH when UP_DN=0. G_OUT<=bin2gray(new B_OUT).
  - Otherwise: all registers hold; WRAP<=0.
- Output alignment:
  - G_OUT is computed from the next binary value, not the current one, so G_OUT always equals bin2gray(B_OUT) in the same cycle.
  - No cycle of skew between B_OUT and G_OUT is permitted.
- Latency: one clock from a control input to B_OUT/G_OUT/WRAP.
- Wrap: WRAP<=1 for exactly one cycle on an EN step where:
  - UP_DN=1 and B_OUT=all-ones, giving next value 0; or
  - UP_DN=0 and B_OUT=0, giving next value all-ones.
  - Consecutive wrap steps (e.g. WIDTH=2 held counting) each produce a pulse.
- Gray property:
  - Every EN-only step changes exactly one bit of G_OUT, including wrap steps in both directions.
  - LOAD and CLR may change multiple bits.
- Direction change: UP_DN may toggle on any cycle. It takes effect on the same edge, and TC reflects the new direction combinationally.
- Simultaneous events:
  - CLR with LOAD/EN: clear wins.
  - LOAD with EN: load wins and the loaded value is not incremented on that edge.
  - LOAD_VAL all-ones with UP_DN=1 makes TC=1 the next cycle, with no WRAP pulse.
- Reset mid-operation: asserting RST during counting aborts that count asynchronously. Any in-flight WRAP pulse is cleared.
- Width: all arithmetic is modulo 2^WIDTH. No carry-out port; TC and WRAP are the only overflow indication.

Decomposition:
- Shared package gray_pkg holds:
  - function bin2gray(WIDTH), combinational XOR-shift;
  - function gray2bin, used by the bench scoreboard;
  - constant GRAY_MAX_WIDTH=16.
- One natural sub-module: gray_next_logic.
  - Combinational; computes next binary value, next Gray value and the wrap flag from B_OUT and controls.
  - The top holds only the three register groups and the TC decode.

Test Plan:
- Reset/up-count: RST pulse, then EN=1, UP_DN=1 for 17 cycles (WIDTH=4).
  - B_OUT steps 0,1,...,15,0,1.
  - G_OUT steps 0000,0001,0011,0010,...,1000,0000,0001.
  - TC=1 only while B_OUT=15.
  - WRAP=1 exactly in the cycle B_OUT returns to 0.
- Down-count wrap: LOAD_VAL=2 loaded, then EN=1, UP_DN=0 for 4 cycles.
  - B_OUT 2,1,0,15,14.
  - G_OUT 0011,0001,0000,1000,1001.
  - WRAP pulse in the cycle B_OUT=15.
- Priority: CLR=1, LOAD=1 (LOAD_VAL=9), EN=1 together from B_OUT=5.
  - Next B_OUT=0, G_OUT=0000, WRAP=0.
  - Next cycle with CLR=0 and LOAD/EN unchanged: B_OUT=9, G_OUT=1101 (no increment).
- Hold and direction change: EN=0 for 3 cycles at B_OUT=7.
  - Outputs hold at 7/0100.
  - Toggling UP_DN flips TC from 0 to 1 combinationally at B_OUT=0 after CLR.
- Async reset mid-count: assert RST between edges at B_OUT=12.
  - B_OUT/G_OUT go to 0 before the next edge.
  - WRAP=0.
  - Counting resumes from 0 after release.
- Gray property check: random EN/UP_DN sequence for 1000 cycles with LOAD/CLR low.
  - Scoreboard confirms popcount(G_OUT xor previous G_OUT)=1 on every enabled step.
  - Scoreboard confirms gray2bin(G_OUT)=B_OUT every cycle.
